fifo_wr_ctrl: RTL

Parametrised write-side controller for the asynchronous FIFO. It runs in the write clock domain and owns the binary write pointer, the Gray-coded pointer exported to the read domain, and the memory write address and enable. It derives registered full, almost-full and fill-level status from the read pointer after that pointer has been synchronised into this domain. It replaces the fixed 4-bit write-side logic with a depth-generic block that also blocks writes when full and reports overflow.

---
 rtl/fifo_wr_ctrl_if.sv | 30 +++
 rtl/fifo_wr_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the asynchronous FIFO: request, synchronised read pointer,
// exported Gray pointer, memory write port and status flags.
interface fifo_wr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic                  winc;
    logic [PTR_W-1:0]      rptr_gray_sync;
    logic                  ovf_clr;
    logic [PTR_W-1:0]      wptr_gray;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wen;
    logic                  full;
    logic                  afull;
    logic [PTR_W-1:0]      wlevel;
    logic                  overflow;

    // Producer / status consumer side
    modport master (
        output winc, rptr_gray_sync, ovf_clr,
        input  wptr_gray, waddr, wen, full, afull, wlevel, overflow
    );

    // Write controller side
    modport slave (
        input  winc, rptr_gray_sync, ovf_clr,
        output wptr_gray, waddr, wen, full, afull, wlevel, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the asynchronous FIFO: binary/Gray write pointer,
// memory write port, and registered full / almost-full / fill-level status
// derived from the synchronised Gray read pointer.
// Optional feature macro: FIFO_WR_OVF_EN builds the sticky overflow flag with
// its ovf_clr; without it overflow is tied low and ovf_clr is ignored.
module fifo_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
    input  logic           CLK,
    input  logic           RST,
    fifo_wr_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    // Full when the write Gray pointer equals the read Gray pointer with its top two bits flipped
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_WIDTH - 1);
    localparam logic [PTR_W-1:0] AFULL_THR = PTR_W'(AFULL_LEVEL);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wgray;
    logic [PTR_W-1:0] level;
    logic             full_q;
    logic             afull_q;

    logic             wen;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] level_next;
    logic             full_next;
    logic             afull_next;

    // Next pointer and status, folding this edge's write and the current read pointer together
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PTR_W; i++) begin
            rbin[i] = ^(bus.rptr_gray_sync >> i);
        end
        wen        = bus.winc & ~full_q;
        wbin_next  = wbin + PTR_W'(wen);
        wgray_next = wbin_next ^ (wbin_next >> 1);
        level_next = wbin_next - rbin;
        full_next  = (wgray_next == (bus.rptr_gray_sync ^ FULL_MASK));
        afull_next = (level_next >= AFULL_THR);
    end

    // Pointer and status registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wbin    <= '0;
            wgray   <= '0;
            level   <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wbin    <= wbin_next;
            wgray   <= wgray_next;
            level   <= level_next;
            full_q  <= full_next;
            afull_q <= afull_next;
        end
    end

`ifdef FIFO_WR_OVF_EN
    logic ovf_q;

    // Sticky overflow: set by a write attempt while full, clear wins on the same edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end else if (bus.winc && full_q) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.overflow   = 1'b0;
`endif

    assign bus.wptr_gray = wgray;
    assign bus.waddr     = wbin[ADDR_WIDTH-1:0];
    assign bus.wen       = wen;
    assign bus.full      = full_q;
    assign bus.afull     = afull_q;
    assign bus.wlevel    = level;
endmodule
